// File: rtl/beep_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : beep_scheduler
// Brief   : Priority-arbitrated buzzer sequencer (OVER > START > EVT) driving
//           a registered square-wave beep through a tone/gap state machine.
// Rev     : 1.0
// ============================================================================
module beep_scheduler #(
    parameter int TICK_DIV = 100000,
    parameter int HP_BASE  = 12500,
    parameter int NOTE_MS  = 150,
    parameter int GAP_MS   = 30,
    parameter int EVT_MS   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gamemode,
    input  logic       evt_req,
    input  logic       mute,
    output logic       beep,
    output logic       busy,
    output logic [1:0] cur_snd
);

    localparam int c_MS_MAX0 = (NOTE_MS > GAP_MS) ? NOTE_MS : GAP_MS;
    localparam int c_MS_MAX  = (c_MS_MAX0 > EVT_MS) ? c_MS_MAX0 : EVT_MS;
    localparam int c_MSW     = (c_MS_MAX > 1) ? $clog2(c_MS_MAX) : 1;
    localparam int c_DIVW    = $clog2(TICK_DIV);
    localparam int c_HPW     = $clog2(4 * HP_BASE);

    localparam logic [c_DIVW-1:0] c_DIV_LAST  = c_DIVW'(TICK_DIV - 1);
    localparam logic [c_DIVW-1:0] c_DIV_ONE   = c_DIVW'(1);
    localparam logic [c_MSW-1:0]  c_NOTE_LAST = c_MSW'(NOTE_MS - 1);
    localparam logic [c_MSW-1:0]  c_GAP_LAST  = c_MSW'(GAP_MS - 1);
    localparam logic [c_MSW-1:0]  c_EVT_LAST  = c_MSW'(EVT_MS - 1);
    localparam logic [c_MSW-1:0]  c_MS_ONE    = c_MSW'(1);
    localparam logic [c_HPW-1:0]  c_T0_LAST   = c_HPW'(4 * HP_BASE - 1);
    localparam logic [c_HPW-1:0]  c_T1_LAST   = c_HPW'(3 * HP_BASE - 1);
    localparam logic [c_HPW-1:0]  c_T2_LAST   = c_HPW'(2 * HP_BASE - 1);
    localparam logic [c_HPW-1:0]  c_HP_ONE    = c_HPW'(1);

    localparam logic [1:0] c_SND_NONE  = 2'b00;
    localparam logic [1:0] c_SND_EVT   = 2'b01;
    localparam logic [1:0] c_SND_START = 2'b10;
    localparam logic [1:0] c_SND_OVER  = 2'b11;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_TONE = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        r_snd;
    logic [1:0]        r_prev_gm;
    logic [1:0]        r_idx;
    logic [c_DIVW-1:0] r_div;
    logic [c_MSW-1:0]  r_ms;
    logic [c_HPW-1:0]  r_hp;
    logic              r_tone;
    logic              r_beep;
    logic              r_busy;

    logic              w_ent_start;
    logic              w_ent_over;
    logic              w_abort;
    logic              w_evt_go;
    logic              w_start;
    logic [1:0]        w_start_snd;
    logic              w_tick_end;
    logic              w_tone_end;
    logic              w_gap_end;
    logic [c_HPW-1:0]  w_hp_last;
    logic [c_MSW-1:0]  w_note_last;

    assign w_ent_start = (gamemode == 2'b00) && (r_prev_gm != 2'b00);
    assign w_ent_over  = (gamemode == 2'b11) && (r_prev_gm != 2'b11);
    assign w_abort     = (r_state != c_ST_IDLE) &&
                         (((r_snd == c_SND_START) && (gamemode != 2'b00)) ||
                          ((r_snd == c_SND_OVER)  && (gamemode != 2'b11)));
    assign w_evt_go    = evt_req && ((r_state == c_ST_IDLE) || (r_snd == c_SND_EVT));
    // Mode triggers outrank aborts; an evt_req coinciding with either is dropped.
    assign w_start     = w_ent_over || w_ent_start || (!w_abort && w_evt_go);
    assign w_start_snd = w_ent_over ? c_SND_OVER : (w_ent_start ? c_SND_START : c_SND_EVT);

    assign w_tick_end  = (r_div == c_DIV_LAST);
    assign w_note_last = (r_snd == c_SND_EVT) ? c_EVT_LAST : c_NOTE_LAST;
    assign w_tone_end  = w_tick_end && (r_ms == w_note_last);
    assign w_gap_end   = w_tick_end && (r_ms == c_GAP_LAST);

    always_comb begin
        w_hp_last = c_T2_LAST;
        case (r_snd)
            c_SND_START: w_hp_last = (r_idx == 2'd0) ? c_T0_LAST :
                                     (r_idx == 2'd1) ? c_T1_LAST : c_T2_LAST;
            c_SND_OVER:  w_hp_last = (r_idx == 2'd0) ? c_T2_LAST :
                                     (r_idx == 2'd1) ? c_T1_LAST : c_T0_LAST;
            default:     w_hp_last = c_T2_LAST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_snd     <= c_SND_NONE;
            r_prev_gm <= 2'b01;
            r_idx     <= 2'd0;
            r_div     <= '0;
            r_ms      <= '0;
            r_hp      <= '0;
            r_tone    <= 1'b0;
            r_beep    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_prev_gm <= gamemode;
            if (w_start) begin
                r_state <= c_ST_TONE;
                r_snd   <= w_start_snd;
                r_busy  <= 1'b1;
                r_idx   <= 2'd0;
                r_div   <= '0;
                r_ms    <= '0;
                r_hp    <= '0;
                r_tone  <= 1'b0;
                r_beep  <= 1'b0;
            end else if (w_abort) begin
                r_state <= c_ST_IDLE;
                r_snd   <= c_SND_NONE;
                r_busy  <= 1'b0;
                r_div   <= '0;
                r_ms    <= '0;
                r_hp    <= '0;
                r_tone  <= 1'b0;
                r_beep  <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_TONE: begin
                        if (w_tone_end) begin
                            r_div  <= '0;
                            r_ms   <= '0;
                            r_hp   <= '0;
                            r_tone <= 1'b0;
                            r_beep <= 1'b0;
                            if ((r_snd != c_SND_EVT) && (r_idx < 2'd2)) begin
                                r_state <= c_ST_GAP;
                            end else begin
                                r_state <= c_ST_IDLE;
                                r_snd   <= c_SND_NONE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_div <= w_tick_end ? '0 : r_div + c_DIV_ONE;
                            r_ms  <= w_tick_end ? r_ms + c_MS_ONE : r_ms;
                            // Beep is computed from the next tone value so mute is the only lag.
                            if (r_hp == w_hp_last) begin
                                r_hp   <= '0;
                                r_tone <= ~r_tone;
                                r_beep <= ~r_tone & ~mute;
                            end else begin
                                r_hp   <= r_hp + c_HP_ONE;
                                r_beep <= r_tone & ~mute;
                            end
                        end
                    end
                    c_ST_GAP: begin
                        r_beep <= 1'b0;
                        if (w_gap_end) begin
                            r_state <= c_ST_TONE;
                            r_idx   <= r_idx + 2'd1;
                            r_div   <= '0;
                            r_ms    <= '0;
                            r_hp    <= '0;
                            r_tone  <= 1'b0;
                        end else begin
                            r_div <= w_tick_end ? '0 : r_div + c_DIV_ONE;
                            r_ms  <= w_tick_end ? r_ms + c_MS_ONE : r_ms;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_snd   <= c_SND_NONE;
                        r_busy  <= 1'b0;
                        r_beep  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign beep    = r_beep;
    assign busy    = r_busy;
    assign cur_snd = r_snd;

endmodule
`default_nettype wire

// File: tb/tb_beep_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_beep_scheduler
// Brief   : Directed-vector bench for beep_scheduler with small timing params.
// Rev     : 1.0
// ============================================================================
module tb_beep_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gamemode;
    logic       evt_req;
    logic       mute;
    logic       beep;
    logic       busy;
    logic [1:0] cur_snd;

    int n_vectors     = 0;
    int n_miscompares = 0;

    beep_scheduler #(
        .TICK_DIV (4),
        .HP_BASE  (1),
        .NOTE_MS  (3),
        .GAP_MS   (1),
        .EVT_MS   (2)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .gamemode (gamemode),
        .evt_req  (evt_req),
        .mute     (mute),
        .beep     (beep),
        .busy     (busy),
        .cur_snd  (cur_snd)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected beep at cycle c (1-based after trigger) of a 3-note jingle:
    // 12-clock notes separated by 4-clock gaps, half-periods hp0/hp1/hp2.
    function automatic logic [31:0] jingle_beep(input int c, input int hp0, input int hp1, input int hp2);
        if (c <= 12)      return 32'(((c - 1)  / hp0) % 2);
        else if (c <= 16) return 32'd0;
        else if (c <= 28) return 32'(((c - 17) / hp1) % 2);
        else if (c <= 32) return 32'd0;
        else              return 32'(((c - 33) / hp2) % 2);
    endfunction

    initial begin
        rst = 1'b1; gamemode = 2'b00; evt_req = 1'b0; mute = 1'b0;
        step(2);
        check_vec("rst_beep", 32'(beep), 32'd0);
        check_vec("rst_busy", 32'(busy), 32'd0);
        check_vec("rst_snd",  32'(cur_snd), 32'd0);

        // 1: START after reset release
        rst = 1'b0;
        step(1);
        check_vec("t1_snd", 32'(cur_snd), 32'd2);
        for (int c = 1; c <= 44; c++) begin
            check_vec("t1_busy", 32'(busy), 32'd1);
            check_vec("t1_beep", 32'(beep), jingle_beep(c, 4, 3, 2));
            if (c < 44) step(1);
        end
        step(1);
        check_vec("t1_end_busy", 32'(busy), 32'd0);
        check_vec("t1_end_snd",  32'(cur_snd), 32'd0);
        check_vec("t1_end_beep", 32'(beep), 32'd0);

        // 2: EVT click from IDLE
        gamemode = 2'b01;
        step(1);
        evt_req = 1'b1;
        step(1);
        evt_req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check_vec("t2_snd",  32'(cur_snd), 32'd1);
            check_vec("t2_beep", 32'(beep), jingle_beep(c, 2, 2, 2));
            if (c < 8) step(1);
        end
        step(1);
        check_vec("t2_end_busy", 32'(busy), 32'd0);
        check_vec("t2_end_snd",  32'(cur_snd), 32'd0);

        // 3: OVER preempts START during note 1
        gamemode = 2'b00;
        step(1);
        check_vec("t3_start_snd", 32'(cur_snd), 32'd2);
        step(17);
        check_vec("t3_note1_beep", 32'(beep), jingle_beep(18, 4, 3, 2));
        gamemode = 2'b11;
        step(1);
        for (int c = 1; c <= 13; c++) begin
            check_vec("t3_snd",  32'(cur_snd), 32'd3);
            check_vec("t3_beep", 32'(beep), jingle_beep(c, 2, 3, 4));
            if (c < 13) step(1);
        end

        // 4a: evt_req during OVER is ignored
        evt_req = 1'b1;
        step(1);
        evt_req = 1'b0;
        for (int c = 14; c <= 44; c++) begin
            check_vec("t4_snd",  32'(cur_snd), 32'd3);
            check_vec("t4_beep", 32'(beep), jingle_beep(c, 2, 3, 4));
            if (c < 44) step(1);
        end
        step(1);
        check_vec("t4_end_busy", 32'(busy), 32'd0);

        // 4b: evt_req coinciding with ent_start
        gamemode = 2'b00;
        evt_req  = 1'b1;
        step(1);
        evt_req = 1'b0;
        for (int c = 1; c <= 44; c++) begin
            check_vec("t4b_snd", 32'(cur_snd), 32'd2);
            if (c < 44) step(1);
        end
        step(1);
        check_vec("t4b_end_busy", 32'(busy), 32'd0);
        step(1);
        check_vec("t4b_no_evt", 32'(cur_snd), 32'd0);

        // 5: muted START keeps timing, beep silent
        gamemode = 2'b01;
        step(1);
        gamemode = 2'b00;
        mute     = 1'b1;
        step(1);
        for (int c = 1; c <= 44; c++) begin
            check_vec("t5_busy", 32'(busy), 32'd1);
            check_vec("t5_beep", 32'(beep), 32'd0);
            if (c < 44) step(1);
        end
        step(1);
        check_vec("t5_end_busy", 32'(busy), 32'd0);

        gamemode = 2'b01;
        step(1);
        gamemode = 2'b00;
        step(1);
        step(4);
        check_vec("t5_muted_hi", 32'(beep), 32'd0);
        mute = 1'b0;
        step(1);
        check_vec("t5_unmute_c6", 32'(beep), 32'd1);
        step(1);
        check_vec("t5_unmute_c7", 32'(beep), 32'd1);
        step(2);
        check_vec("t5_unmute_c9", 32'(beep), 32'd0);

        // 6: reset mid-OVER, then START after release
        gamemode = 2'b11;
        step(1);
        check_vec("t6_over_snd", 32'(cur_snd), 32'd3);
        step(3);
        rst = 1'b1;
        step(1);
        check_vec("t6_rst_beep", 32'(beep), 32'd0);
        check_vec("t6_rst_busy", 32'(busy), 32'd0);
        check_vec("t6_rst_snd",  32'(cur_snd), 32'd0);
        step(1);
        check_vec("t6_rst_hold", 32'(busy), 32'd0);
        rst      = 1'b0;
        gamemode = 2'b00;
        step(1);
        check_vec("t6_start_snd",  32'(cur_snd), 32'd2);
        check_vec("t6_start_busy", 32'(busy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/beep_scheduler.md
Name: beep_scheduler

Overview:
Sound controller for the game buzzer. Watches gamemode transitions and a one-cycle score/event request, and arbitrates three sound sources by fixed priority: OVER jingle > START jingle > EVT click. Sequences multi-note jingles through a tone/gap state machine and generates the square-wave beep output directly. Replaces the per-mode beep mux at the top of the sound path.

Parameters:
TICK_DIV, 100000, clocks per 1 ms timing tick (≥2)
HP_BASE, 12500, base half-period in clocks; tones T0=4*HP_BASE, T1=3*HP_BASE, T2=2*HP_BASE
NOTE_MS, 150, jingle note length in ticks
GAP_MS, 30, silence between jingle notes in ticks
EVT_MS, 50, EVT click length in ticks

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
gamemode  in  2  00 = await start, 01/10 = in play, 11 = game over
evt_req  in  1  one-cycle pulse requesting the EVT click
mute  in  1  level; forces beep low, sequencing continues
beep  out  1  buzzer square wave, registered
busy  out  1  high whenever state ≠ IDLE
cur_snd  out  2  00 none, 01 EVT, 10 START, 11 OVER

Behaviour:
- Reset: state=IDLE, beep=0, busy=0, cur_snd=00; all counters 0; prev_gm=01, so gamemode=00 right after reset fires START.
- Triggers, sampled each cycle: ent_start = (gamemode==00 && prev_gm!=00); ent_over = (gamemode==11 && prev_gm!=11). prev_gm<=gamemode every cycle.
- Arbitration, evaluated in the trigger cycle:
  - ent_over: always starts OVER and preempts anything.
  - ent_start: starts START and preempts EVT.
  - evt_req: starts EVT only when IDLE or EVT is playing (restarts it); ignored during START/OVER.
  - Simultaneous mode trigger and evt_req: the mode sound wins and the evt_req is dropped, not queued.
- Start of any sound: in the trigger cycle n, load the sequence and set note_idx=0, tick and half-period counters=0, beep=0. At n+1: state=TONE, busy=1, cur_snd valid.
- Sequences:
  - START: T0, T1, T2 (rising pitch).
  - OVER: T2, T1, T0.
  - EVT: single T2 note of EVT_MS ticks.
- States:
  - IDLE: beep=0.
  - TONE: the half-period counter counts clocks; beep toggles when it reaches HP-1, then the counter wraps to 0. Note length is NOTE_MS ticks (EVT_MS for EVT). At the end of the note:
    - jingle with note_idx<2: go to GAP.
    - otherwise: go to IDLE.
  - GAP: beep=0 for GAP_MS ticks, then note_idx+1, return to TONE with beep=0 and the half-period counter reset.
- Tick counter: cleared at every sound start and every state entry, so durations are exact: TONE = NOTE_MS*TICK_DIV clocks, GAP = GAP_MS*TICK_DIV clocks.
- Abort rules:
  - START aborts to IDLE the cycle after gamemode≠00 is sampled while START plays (unless ent_over, which starts OVER).
  - OVER aborts when gamemode≠11.
  - EVT is independent of gamemode.
  - An abort drives beep=0 the next cycle.
- Mute: beep output = tone_reg & ~mute, registered, so there is 1-cycle latency from mute to beep. State, counters and busy are unaffected.
- Return to IDLE: beep=0, cur_snd=00, busy=0 in the same cycle.
- rst mid-sound: everything returns to reset values on the next edge; the prev_gm=01 reload means START fires again if gamemode==00.
- Counter widths are sized by $clog2 of their maximum values; no overflow is possible for legal parameters.

Test Plan:
Parameters for all scenarios: TICK_DIV=4, HP_BASE=1, NOTE_MS=3, GAP_MS=1, EVT_MS=2.
1. Reset release with gamemode=00 → START: busy high 44 clocks (3×12 tone + 2×4 gap), cur_snd=10; beep half-periods 4, 3, 2 clocks in successive notes; beep=0 in gaps; then IDLE.
2. In IDLE, pulse evt_req with gamemode=01 → cur_snd=01 for 8 clocks; beep toggles every 2 clocks; then busy=0.
3. During START note 1, gamemode 00→11 → next cycle cur_snd=11 and OVER note 0 plays with half-period 2; START does not resume.
4. evt_req during OVER → ignored, cur_snd stays 11. evt_req in the same cycle as ent_start → START plays, no EVT follows.
5. mute held high throughout START → beep constantly 0, busy timing identical to scenario 1. Release mute mid-note → beep follows the tone one cycle later.
6. Assert rst mid-OVER with gamemode=11 → beep=0, busy=0 after the edge; no OVER retrigger. Then gamemode→00 → START fires.
